// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg : shared rounding/saturation helpers for FIR output stages
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fir_pkg;

  // Working width for round_sat; wide enough for any realistic FIR output.
  localparam int RS_WIDTH = 64;

  localparam int DEF_WIDTH_OUT = 8;
  localparam logic signed [RS_WIDTH-1:0] DEF_OUT_MAX = (64'sd1 <<< (DEF_WIDTH_OUT - 1)) - 64'sd1;
  localparam logic signed [RS_WIDTH-1:0] DEF_OUT_MIN = -(64'sd1 <<< (DEF_WIDTH_OUT - 1));

  typedef struct packed {
    logic                       sat;
    logic signed [RS_WIDTH-1:0] value;
  } round_sat_t;

  // Round half-up by discarding 'shift' LSBs, then clamp to a signed width_out range.
  function automatic round_sat_t round_sat(input logic signed [RS_WIDTH-1:0] in_val,
                                           input int shift,
                                           input int width_out);
    logic signed [RS_WIDTH-1:0] t;
    logic signed [RS_WIDTH-1:0] r;
    logic signed [RS_WIDTH-1:0] max_v;
    logic signed [RS_WIDTH-1:0] min_v;
    round_sat_t res;
    t = in_val;
    if (shift > 0) begin
      t = in_val + (64'sd1 <<< (shift - 1));
    end
    r     = t >>> shift;
    max_v = (64'sd1 <<< (width_out - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width_out - 1));
    res.sat   = 1'b0;
    res.value = r;
    if (r > max_v) begin
      res.sat   = 1'b1;
      res.value = max_v;
    end else if (r < min_v) begin
      res.sat   = 1'b1;
      res.value = min_v;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, simultaneous push+pop allowed when full
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/fir_decim_quant.sv
// ---------------------------------------------------------------------------
// fir_decim_quant : decimate, round/saturate and buffer the FIR output stream
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_decim_quant
  import fir_pkg::*;
#(
  parameter int WIDTH_IN  = 17,
  parameter int WIDTH_OUT = 8,
  parameter int SHIFT     = 4,
  parameter int DECIM     = 2,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [WIDTH_IN-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_OUT-1:0] out_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        sat_flag,
  output logic                        ovf_flag,
  input  logic                        clr_flags
);

  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

  logic [PHASE_W-1:0]   phase;
  logic                 keep;
  round_sat_t           rs;
  logic                 s1_valid;
  logic [WIDTH_OUT-1:0] s1_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WIDTH_OUT-1:0] fifo_rd_data;
  logic                 pop;
  logic                 drop;
  logic                 unused_rs_hi;

  assign keep = in_valid && (phase == '0);

  always_comb begin
    rs = round_sat({{(RS_WIDTH-WIDTH_IN){in_data[WIDTH_IN-1]}}, in_data}, SHIFT, WIDTH_OUT);
  end

  // Saturated value always fits WIDTH_OUT, so the upper bits carry only sign copies.
  assign unused_rs_hi = ^rs.value[RS_WIDTH-1:WIDTH_OUT];

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_data <= rs.value[WIDTH_OUT-1:0];
    end
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd_data;
  assign pop       = out_valid && out_ready;
  assign drop      = s1_valid && fifo_full && !pop;

  // A new set condition dominates a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      sat_flag <= (sat_flag && !clr_flags) || (keep && rs.sat);
      ovf_flag <= (ovf_flag && !clr_flags) || drop;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH_OUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s1_valid),
    .pop     (pop),
    .wr_data (s1_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule

`default_nettype wire

// File: tb/tb_fir_decim_quant.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_quant : directed + randomized bench with a queue-based reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fir_decim_quant;

  localparam int WIDTH_IN  = 17;
  localparam int WIDTH_OUT = 8;
  localparam int SHIFT     = 4;
  localparam int DECIM     = 2;
  localparam int DEPTH     = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [WIDTH_IN-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [WIDTH_OUT-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic sat_flag;
  logic ovf_flag;
  logic clr_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_decim_quant #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT),
    .SHIFT     (SHIFT),
    .DECIM     (DECIM),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag),
    .clr_flags (clr_flags)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: add half an LSB, floor-divide, clamp.
  function automatic int quant(input int x, output bit sat);
    int t, d, r, hi, lo;
    d  = 1 << SHIFT;
    t  = x + d / 2;
    r  = (t >= 0) ? t / d : -((-t + d - 1) / d);
    hi = (1 << (WIDTH_OUT - 1)) - 1;
    lo = -(1 << (WIDTH_OUT - 1));
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return r;
  endfunction

  int mq[$];
  int m_pend_v = 0;
  int m_pend_d = 0;
  int m_phase  = 0;
  int m_sat    = 0;
  int m_ovf    = 0;
  int got[$];

  always @(posedge clk) begin : model
    bit s;
    int nsat, novf, x;
    if (rst) begin
      mq.delete();
      m_pend_v = 0;
      m_phase  = 0;
      m_sat    = 0;
      m_ovf    = 0;
    end else begin
      novf = 0;
      nsat = 0;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (m_pend_v != 0) begin
        if (mq.size() < DEPTH) mq.push_back(m_pend_d);
        else novf = 1;
      end
      m_pend_v = 0;
      if (in_valid) begin
        if (m_phase == 0) begin
          x = in_data;
          m_pend_d = quant(x, s);
          m_pend_v = 1;
          nsat = s ? 1 : 0;
        end
        m_phase = (m_phase + 1) % DECIM;
      end
      m_sat = ((m_sat != 0 && !clr_flags) || nsat != 0) ? 1 : 0;
      m_ovf = ((m_ovf != 0 && !clr_flags) || novf != 0) ? 1 : 0;
    end
  end

  always @(negedge clk) begin : compare
    if ($time > 6) begin
      chk("out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
      chk("level", level, mq.size());
      chk("sat_flag", sat_flag, m_sat);
      chk("ovf_flag", ovf_flag, m_ovf);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      if (!rst && out_valid && out_ready) got.push_back(int'(out_data));
    end
  end

  task automatic cyc(input bit v, input int d, input bit rdy, input bit clr);
    @(posedge clk); #2;
    rst       = 1'b0;
    in_valid  = v;
    in_data   = WIDTH_IN'(d);
    out_ready = rdy;
    clr_flags = clr;
  endtask

  task automatic do_rst();
    @(posedge clk); #2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic chk_got(input string name, input int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) chk(name, got[i], exp[i]);
    end
  endtask

  initial begin : driver
    bit s;
    int d;
    logic signed [WIDTH_IN-1:0] r17;
    int e1[$];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_level", level, 0);
    chk("reset_sat", sat_flag, 0);
    chk("reset_ovf", ovf_flag, 0);
    chk("model_quant_56", quant(56, s), 4);
    chk("model_quant_m4000", quant(-4000, s), -128);

    // Rounding: kept samples on even phases, fillers dropped by decimation.
    e1 = '{56, -24, 8, -8, 7};
    foreach (e1[i]) begin
      cyc(1'b1, e1[i], 1'b1, 1'b0);
      cyc(1'b1, 999, 1'b1, 1'b0);
    end
    repeat (4) cyc(1'b0, 0, 1'b1, 1'b0);
    chk_got("t1_round", '{4, -1, 1, 0, 0});
    chk("t1_sat", sat_flag, 0);

    // Saturation and flag clear/set priority.
    got.delete();
    cyc(1'b1, 4000, 1'b1, 1'b0);
    cyc(1'b1, 0, 1'b1, 1'b0);
    cyc(1'b1, -4000, 1'b1, 1'b0);
    cyc(1'b1, 0, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 0, 1'b1, 1'b0);
    chk_got("t2_sat_vals", '{127, -128});
    chk("t2_sat_set", sat_flag, 1);
    cyc(1'b0, 0, 1'b1, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("t2_sat_cleared", sat_flag, 0);
    cyc(1'b1, 4000, 1'b1, 1'b1);
    cyc(1'b1, 0, 1'b1, 1'b0);
    chk("t2_set_wins", sat_flag, 1);
    repeat (4) cyc(1'b0, 0, 1'b1, 1'b0);

    // Decimation and two-edge latency.
    got.delete();
    cyc(1'b1, 16, 1'b1, 1'b0);
    cyc(1'b1, 32, 1'b1, 1'b0);
    chk("t3_not_yet_valid", out_valid, 0);
    cyc(1'b1, 48, 1'b1, 1'b0);
    chk("t3_latency", out_valid, 1);
    for (int i = 4; i <= 8; i++) cyc(1'b1, 16 * i, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 0, 1'b1, 1'b0);
    chk_got("t3_decim", '{1, 3, 5, 7});

    // Backpressure: 6 kept, 4 stored, 2 dropped.
    got.delete();
    for (int i = 0; i < 12; i++) cyc(1'b1, 16 * i, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("t4_level_full", level, 4);
    chk("t4_ovf", ovf_flag, 1);
    repeat (4) cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("t4_drained", level, 0);
    chk_got("t4_order", '{0, 2, 4, 6});

    // Full FIFO with simultaneous push and pop.
    cyc(1'b0, 0, 1'b0, 1'b1);
    got.delete();
    for (int i = 20; i < 28; i++) cyc(1'b1, 16 * i, 1'b0, 1'b0);
    cyc(1'b1, 16 * 28, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("t5_level_held", level, 4);
    chk("t5_no_ovf", ovf_flag, 0);
    repeat (6) cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk_got("t5_order", '{20, 22, 24, 26, 28});

    // Reset mid-operation flushes FIFO and stage 1.
    got.delete();
    for (int i = 0; i < 7; i++) cyc(1'b1, 16 * i, 1'b0, 1'b0);
    do_rst();
    chk("t6_level_before", level, 3);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_level", level, 0);
    cyc(1'b1, 16 * 9, 1'b1, 1'b0);
    cyc(1'b1, 16 * 11, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 0, 1'b1, 1'b0);
    chk_got("t6_only", '{9});

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom % 150 == 0) begin
        do_rst();
      end else begin
        if ($urandom % 4 == 0) begin
          r17 = WIDTH_IN'($urandom);
          d = r17;
        end else begin
          d = int'($urandom_range(4200)) - 2100;
        end
        cyc(($urandom % 4) != 0, d, ($urandom % 10) < 6, ($urandom % 20) == 0);
      end
    end
    repeat (8) cyc(1'b0, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
